// File: rtl/uart_tx_fifo.sv
// ============================================================================
//  Module   : uart_tx_fifo
//  Brief    : Valid/ready byte sink with a small FIFO feeding an 8N1 UART
//             transmitter (start, 8 data bits LSB-first, stop).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_fifo #(
   parameter int CLKS_PER_BIT = 87,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic [7:0]                           s_data,
   input  logic                                 s_valid,
   output logic                                 s_ready,
   output logic                                 tx,
   output logic                                 busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_count
);

   localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
   localparam int c_cnt_w  = $clog2(FIFO_DEPTH + 1);
   localparam int c_baud_w = $clog2(CLKS_PER_BIT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   logic [7:0]          r_mem [FIFO_DEPTH];
   logic [c_ptr_w-1:0]  r_wr_ptr;
   logic [c_ptr_w-1:0]  r_rd_ptr;
   logic [c_cnt_w-1:0]  r_count;
   logic                r_s_ready;
   state_t              r_state;
   logic [c_baud_w-1:0] r_baud;
   logic [2:0]          r_bit;
   logic [7:0]          r_shift;
   logic                r_tx;
   logic                r_busy;

   state_t              w_state_n;
   logic [c_baud_w-1:0] w_baud_n;
   logic [2:0]          w_bit_n;
   logic [7:0]          w_shift_n;
   logic                w_pop;
   logic                w_push;
   logic                w_baud_last;
   logic                w_not_empty;
   logic [c_cnt_w-1:0]  w_count_n;
   logic                w_tx_n;

   assign w_push      = s_valid & r_s_ready;
   assign w_not_empty = (r_count != '0);
   assign w_baud_last = (r_baud == c_baud_w'(CLKS_PER_BIT - 1));
   assign w_count_n   = r_count + c_cnt_w'(w_push) - c_cnt_w'(w_pop);

   always_comb begin
      w_state_n = r_state;
      w_baud_n  = r_baud + c_baud_w'(1);
      w_bit_n   = r_bit;
      w_shift_n = r_shift;
      w_pop     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_baud_n = '0;
            if (w_not_empty) begin
               w_pop     = 1'b1;
               w_shift_n = r_mem[r_rd_ptr];
               w_state_n = S_START;
            end
         end
         S_START: begin
            if (w_baud_last) begin
               w_baud_n  = '0;
               w_bit_n   = 3'd0;
               w_state_n = S_DATA;
            end
         end
         S_DATA: begin
            if (w_baud_last) begin
               w_baud_n  = '0;
               w_shift_n = {1'b0, r_shift[7:1]};
               if (r_bit == 3'd7) w_state_n = S_STOP;
               else               w_bit_n   = r_bit + 3'd1;
            end
         end
         S_STOP: begin
            // Chain straight into the next start bit so frames stay contiguous.
            if (w_baud_last) begin
               w_baud_n = '0;
               if (w_not_empty) begin
                  w_pop     = 1'b1;
                  w_shift_n = r_mem[r_rd_ptr];
                  w_state_n = S_START;
               end else begin
                  w_state_n = S_IDLE;
               end
            end
         end
         default: w_state_n = S_IDLE;
      endcase

      // tx is registered from the next state so the line moves on the same edge as the FSM.
      case (w_state_n)
         S_START: w_tx_n = 1'b0;
         S_DATA:  w_tx_n = w_shift_n[0];
         default: w_tx_n = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= s_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_s_ready <= 1'b1;
         r_state   <= S_IDLE;
         r_baud    <= '0;
         r_bit     <= 3'd0;
         r_shift   <= 8'd0;
         r_tx      <= 1'b1;
         r_busy    <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
         r_count   <= w_count_n;
         r_s_ready <= (w_count_n != c_cnt_w'(FIFO_DEPTH));
         r_state   <= w_state_n;
         r_baud    <= w_baud_n;
         r_bit     <= w_bit_n;
         r_shift   <= w_shift_n;
         r_tx      <= w_tx_n;
         r_busy    <= (w_state_n != S_IDLE);
      end
   end

   assign s_ready    = r_s_ready;
   assign tx         = r_tx;
   assign busy       = r_busy;
   assign fifo_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// ============================================================================
//  Module   : tb_uart_tx_fifo
//  Brief    : Directed self-checking bench for uart_tx_fifo (CLKS_PER_BIT=4,
//             FIFO_DEPTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx_fifo;

   localparam int c_cpb   = 4;
   localparam int c_depth = 4;

   logic       clk;
   logic       rst_n;
   logic [7:0] s_data;
   logic       s_valid;
   logic       s_ready;
   logic       tx;
   logic       busy;
   logic [2:0] fifo_count;

   int n_checks = 0;
   int n_pass   = 0;

   uart_tx_fifo #(
      .CLKS_PER_BIT (c_cpb),
      .FIFO_DEPTH   (c_depth)
   ) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .s_data     (s_data),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Checks the line from frame cycle 'first' onwards; on return the bench sits on the
   // cycle that follows the last stop-bit cycle.
   task automatic check_frame(input logic [7:0] b, input int first);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      for (int i = first; i < 10 * c_cpb; i++) begin
         check($sformatf("tx_%02h_c%0d", b, i), {31'd0, tx}, {31'd0, f[i / c_cpb]});
         check("busy_in_frame", {31'd0, busy}, 32'd1);
         tick();
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = 8'h00;

      // T1 reset
      repeat (3) tick();
      check("rst_tx",      {31'd0, tx},      32'd1);
      check("rst_busy",    {31'd0, busy},    32'd0);
      check("rst_s_ready", {31'd0, s_ready}, 32'd1);
      check("rst_count",   {29'd0, fifo_count}, 32'd0);
      rst_n = 1'b1;
      repeat (2) tick();
      check("idle_tx", {31'd0, tx}, 32'd1);

      // T2 single byte
      s_data = 8'hA5; s_valid = 1'b1;
      tick();
      s_valid = 1'b0;
      check("t2_count_after_push", {29'd0, fifo_count}, 32'd1);
      check("t2_tx_still_idle",    {31'd0, tx},         32'd1);
      tick();
      check("t2_count_after_pop",  {29'd0, fifo_count}, 32'd0);
      check_frame(8'hA5, 0);
      check("t2_busy_end", {31'd0, busy}, 32'd0);
      check("t2_tx_end",   {31'd0, tx},   32'd1);
      repeat (3) tick();

      // T3 FIFO full: six consecutive pushes, the sixth is held off
      s_valid = 1'b1;
      s_data = 8'h01; tick();
      check("t3_count_e1", {29'd0, fifo_count}, 32'd1);
      s_data = 8'h02; tick();
      check("t3_count_e2", {29'd0, fifo_count}, 32'd1);
      check("t3_tx_start", {31'd0, tx}, 32'd0);
      s_data = 8'h03; tick();
      s_data = 8'h04; tick();
      s_data = 8'h05; tick();
      check("t3_count_full", {29'd0, fifo_count}, 32'd4);
      check("t3_ready_low",  {31'd0, s_ready},    32'd0);
      s_data = 8'h06;
      repeat (36) tick();
      check("t3_ready_low_stop", {31'd0, s_ready}, 32'd0);
      check("t3_count_stop",     {29'd0, fifo_count}, 32'd4);
      check("t3_tx_stop",        {31'd0, tx}, 32'd1);
      tick();
      check("t3_ready_after_pop2", {31'd0, s_ready}, 32'd1);
      check("t3_count_after_pop2", {29'd0, fifo_count}, 32'd3);
      check("t3_tx_f2_c0", {31'd0, tx}, 32'd0);
      tick();
      s_valid = 1'b0;
      check("t3_count_byte6", {29'd0, fifo_count}, 32'd4);
      check("t3_ready_low2",  {31'd0, s_ready},    32'd0);
      check_frame(8'h02, 1);
      check_frame(8'h03, 0);
      check_frame(8'h04, 0);
      check_frame(8'h05, 0);
      check_frame(8'h06, 0);
      check("t3_busy_end",  {31'd0, busy}, 32'd0);
      check("t3_count_end", {29'd0, fifo_count}, 32'd0);
      repeat (3) tick();

      // T4 back-to-back 0x00 then 0xFF, 80 contiguous cycles
      s_valid = 1'b1; s_data = 8'h00; tick();
      s_data = 8'hFF; tick();
      s_valid = 1'b0;
      check_frame(8'h00, 0);
      check_frame(8'hFF, 0);
      check("t4_busy_end", {31'd0, busy}, 32'd0);
      check("t4_tx_end",   {31'd0, tx},   32'd1);
      repeat (3) tick();

      // T5 reset during DATA bit 3 with two bytes queued
      s_valid = 1'b1; s_data = 8'h00; tick();
      s_data = 8'h5A; tick();
      s_data = 8'hC3; tick();
      s_valid = 1'b0;
      repeat (16) tick();
      check("t5_count_pre", {29'd0, fifo_count}, 32'd2);
      check("t5_tx_bit3",   {31'd0, tx}, 32'd0);
      rst_n = 1'b0;
      #1;
      check("t5_tx_rst",    {31'd0, tx},   32'd1);
      check("t5_busy_rst",  {31'd0, busy}, 32'd0);
      check("t5_count_rst", {29'd0, fifo_count}, 32'd0);
      check("t5_ready_rst", {31'd0, s_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("t5_quiet_tx",   {31'd0, tx},   32'd1);
         check("t5_quiet_busy", {31'd0, busy}, 32'd0);
      end
      s_valid = 1'b1; s_data = 8'h3C; tick();
      s_valid = 1'b0; tick();
      check_frame(8'h3C, 0);
      check("t5_busy_end", {31'd0, busy}, 32'd0);
      repeat (3) tick();

      // T6 push in the same cycle the idle FSM pops
      s_valid = 1'b1; s_data = 8'h11; tick();
      s_data = 8'h22; tick();
      s_valid = 1'b0;
      check("t6_count_pushpop", {29'd0, fifo_count}, 32'd1);
      check_frame(8'h11, 0);
      check_frame(8'h22, 0);
      check("t6_busy_end",  {31'd0, busy}, 32'd0);
      check("t6_count_end", {29'd0, fifo_count}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
